// File: rtl/pc_fetch_unit.sv
// Purpose : PC register and instruction-fetch request stage; applies branch/JAL/JALR redirects, flags misaligned targets.
// Latency : one fetch address per cycle; a redirect appears on if_addr one cycle after it is applied, with flush high that cycle.
// Backpress: if_ready low holds if_req/if_addr stable; stall only blocks starting a new request; redirects during an open request wait in pend.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    output logic        if_req,
    input  logic        if_ready,
    output logic [31:0] if_addr,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misaligned
);

    // RUN: normal sequential fetch. HOLD: a redirect arrived while a request
    // was still open, target parked in pend. HALT: misaligned target seen.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        open_q, open_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;

    logic        redirect;
    logic [31:0] br_target;
    logic [31:0] jalr_tgt;
    logic [31:0] redir_target;
    logic [31:0] pc_inc;
    logic [31:0] hold_target;
    logic        load_en;
    logic [31:0] load_val;

    // br_imm[31] is shifted out by the half-word scaling and jalr_target[0]
    // is forced to zero, so neither bit reaches any logic.
    logic        unused_bits;
    assign unused_bits = br_imm[31] ^ jalr_target[0];

    // Redirect target selection; JALR wins when both fire in one cycle.
    always_comb begin
        br_target    = br_pc + {br_imm[30:0], 1'b0};
        jalr_tgt     = {jalr_target[31:1], 1'b0};
        redirect     = br_taken | jalr;
        redir_target = jalr ? jalr_tgt : br_target;
        pc_inc       = pc_q + 32'd4;
    end

    // State and datapath registers; reset discards any parked redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0000_0000;
            open_q       <= 1'b0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            open_q       <= open_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        open_d       = open_q;
        flush_d      = 1'b0;
        misaligned_d = misaligned_q;
        load_en      = 1'b0;
        load_val     = pc_q;
        hold_target  = redirect ? redir_target : pend_q;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    if (!if_req || if_ready) begin
                        // No request left hanging: retarget straight away.
                        // Anything accepted this cycle dies in the flush.
                        load_en  = 1'b1;
                        load_val = redir_target;
                    end else begin
                        // Request still open: address must not move yet.
                        pend_d  = redir_target;
                        state_d = HOLD;
                    end
                    open_d = 1'b0;
                end else begin
                    if (if_req && if_ready) begin
                        pc_d = pc_inc;
                    end
                    open_d = if_req && !if_ready;
                end
            end

            HOLD: begin
                // Latest redirect overwrites the parked target.
                if (if_ready) begin
                    load_en  = 1'b1;
                    load_val = hold_target;
                end else begin
                    pend_d = hold_target;
                end
                open_d = 1'b0;
            end

            HALT: begin
                open_d = 1'b0;
            end

            default: begin
                state_d = RUN;
                open_d  = 1'b0;
            end
        endcase

        // Any redirect load pulses flush once; a target with bit 1 set
        // still loads so the faulting address is visible, then halts.
        if (load_en) begin
            pc_d    = load_val;
            flush_d = 1'b1;
            if (load_val[1]) begin
                state_d      = HALT;
                misaligned_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

    // Fetch request outputs; an open request survives a rising stall.
    always_comb begin
        if_req = 1'b0;
        case (state_q)
            RUN:     if_req = !stall || open_q;
            HOLD:    if_req = 1'b1;
            HALT:    if_req = 1'b0;
            default: if_req = 1'b0;
        endcase
        if_addr    = pc_q;
        pc_plus4   = pc_inc;
        flush      = flush_q;
        misaligned = misaligned_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose : self-checking bench for pc_fetch_unit with an expected-output scoreboard.
// Latency : expectations are checked 1 time unit after each rising edge.
// Backpress: exercises if_ready low (open request / HOLD) and stall.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        if_req;
    logic        if_ready;
    logic [31:0] if_addr;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misaligned;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .jalr        (jalr),
        .jalr_target (jalr_target),
        .if_req      (if_req),
        .if_ready    (if_ready),
        .if_addr     (if_addr),
        .pc_plus4    (pc_plus4),
        .flush       (flush),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input logic req, input logic [31:0] addr, input logic fl, input logic mis);
        exp_t e;
        e.req  = req;
        e.addr = addr;
        e.fl   = fl;
        e.mis  = mis;
        sb.push_back(e);
    endtask

    task automatic observe(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".req"},   {31'd0, if_req},     {31'd0, e.req});
            chk({tag, ".addr"},  if_addr,             e.addr);
            chk({tag, ".plus4"}, pc_plus4,            e.addr + 32'd4);
            chk({tag, ".flush"}, {31'd0, flush},      {31'd0, e.fl});
            chk({tag, ".mis"},   {31'd0, misaligned}, {31'd0, e.mis});
        end
    endtask

    task automatic drive(input logic s, input logic bt, input logic [31:0] bpc, input logic [31:0] bimm,
                         input logic j, input logic [31:0] jt, input logic rdy);
        stall       = s;
        br_taken    = bt;
        br_pc       = bpc;
        br_imm      = bimm;
        jalr        = j;
        jalr_target = jt;
        if_ready    = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    // Push the expectation for the next cycle, clock once, then compare.
    task automatic cyc(input string tag, input logic req, input logic [31:0] addr, input logic fl, input logic mis);
        expect_out(req, addr, fl, mis);
        @(posedge clk);
        #1;
        observe(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        expect_out(1'b1, 32'h0, 1'b0, 1'b0);
        observe("rst");
        rst = 1'b0;

        // Sequential fetch.
        cyc("seq4", 1'b1, 32'h4, 1'b0, 1'b0);
        cyc("seq8", 1'b1, 32'h8, 1'b0, 1'b0);
        cyc("seqC", 1'b1, 32'hC, 1'b0, 1'b0);

        // Branch redirects with no open request.
        drive(1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h0, 1'b1);
        cyc("br120", 1'b1, 32'h120, 1'b1, 1'b0);
        idle();
        cyc("br120_nxt", 1'b1, 32'h124, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h100, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1);
        cyc("brneg", 1'b1, 32'hF0, 1'b1, 1'b0);
        idle();
        cyc("brneg_nxt", 1'b1, 32'hF4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h8, 1'b0, 32'h0, 1'b1);
        cyc("brwrap", 1'b1, 32'h0, 1'b1, 1'b0);
        idle();
        cyc("brwrap_nxt", 1'b1, 32'h4, 1'b0, 1'b0);

        // JALR to the top word, then pc+4 wraps to zero.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFD, 1'b1);
        cyc("jalr_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        idle();
        cyc("pcwrap", 1'b1, 32'h0, 1'b0, 1'b0);

        // Open request at 0x40; redirects park in pend, latest wins.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b1);
        cyc("to40", 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc("open40", 1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0);
        cyc("hold_br", 1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h305, 1'b0);
        cyc("hold_jalr", 1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc("hold_rel", 1'b0, 32'h304, 1'b1, 1'b0);

        // Stall with nothing open: no request, PC frozen, single flush pulse.
        cyc("stall_a", 1'b0, 32'h304, 1'b0, 1'b0);
        cyc("stall_b", 1'b0, 32'h304, 1'b0, 1'b0);

        // Branch and JALR together: JALR wins.
        drive(1'b0, 1'b1, 32'h70, 32'h8, 1'b1, 32'h90, 1'b1);
        cyc("both", 1'b1, 32'h90, 1'b1, 1'b0);

        // Enter HOLD, then reset: pend discarded, no flush.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc("open90", 1'b1, 32'h90, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h0, 1'b0);
        cyc("hold90", 1'b1, 32'h90, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        #1;
        expect_out(1'b1, 32'h0, 1'b0, 1'b0);
        observe("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("after_rst", 1'b1, 32'h4, 1'b0, 1'b0);

        // Misaligned target: load, halt, flag sticks, redirects ignored.
        drive(1'b0, 1'b1, 32'h100, 32'h1, 1'b0, 32'h0, 1'b1);
        cyc("mis", 1'b0, 32'h102, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h400, 1'b1);
        cyc("halt_j", 1'b0, 32'h102, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h200, 32'h10, 1'b0, 32'h0, 1'b1);
        cyc("halt_b", 1'b0, 32'h102, 1'b0, 1'b1);

        // Reset leaves HALT and clears the flag.
        rst = 1'b1;
        idle();
        #1;
        expect_out(1'b1, 32'h0, 1'b0, 1'b0);
        observe("rst_halt");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_halt", 1'b1, 32'h4, 1'b0, 1'b0);

        chk("sb_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
